// File: rtl/alu_issue_pkg.sv
// Shared constants for the operand-issue stage and the ALU it feeds.
// Optional write-to-read forwarding in gpr_file is enabled by defining ISSUE_BYPASS_EN.
package alu_issue_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALUOP_W    = 3;
  localparam int IMM_W      = 16;

  typedef enum logic [ALUOP_W-1:0] {
    ALUOP_ADD = 3'd0,
    ALUOP_SUB = 3'd1,
    ALUOP_AND = 3'd2,
    ALUOP_OR  = 3'd3,
    ALUOP_XOR = 3'd4,
    ALUOP_SLT = 3'd5,
    ALUOP_SLL = 3'd6,
    ALUOP_SRL = 3'd7
  } aluop_e;

endpackage

// File: rtl/alu_issue_stage_gpr_file.sv
// General-purpose register file: two async read ports, one sync write port, r0 hardwired to zero.
// With ISSUE_BYPASS_EN defined, a same-cycle write is forwarded to a matching read port.
module gpr_file
  import alu_issue_pkg::REG_ADDR_W;
#(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [REG_ADDR_W-1:0] raddr_a_i,
  input  logic [REG_ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0]     rdata_a_o,
  output logic [DATA_W-1:0]     rdata_b_o
);

  logic [DATA_W-1:0] regs_q [REG_N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
    rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];
`ifdef ISSUE_BYPASS_EN
    // Forward the in-flight write so the accepted operand sees it this cycle.
    if (we_i && (waddr_i != '0) && (waddr_i == raddr_a_i)) rdata_a_o = wdata_i;
    if (we_i && (waddr_i != '0) && (waddr_i == raddr_b_i)) rdata_b_o = wdata_i;
`endif
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-issue stage: reads rs/rt, selects register or extended immediate for B, and holds
// A/B/opcode in a single valid/ready output slot. ISSUE_BYPASS_EN enables GPR write forwarding.
module alu_issue_stage
  import alu_issue_pkg::REG_ADDR_W;
  import alu_issue_pkg::ALUOP_W;
  import alu_issue_pkg::IMM_W;
#(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs,
  input  logic [REG_ADDR_W-1:0] in_rt,
  input  logic [IMM_W-1:0]      in_imm,
  input  logic                  in_use_imm,
  input  logic                  in_imm_sext,
  input  logic [ALUOP_W-1:0]    in_aluop,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_a,
  output logic [DATA_W-1:0]     out_b,
  output logic [ALUOP_W-1:0]    out_aluop
);

  logic [DATA_W-1:0]  rd_a;
  logic [DATA_W-1:0]  rd_b;
  logic [DATA_W-1:0]  imm_ext;
  logic [DATA_W-1:0]  b_d;
  logic               accept;

  logic               valid_q;
  logic [DATA_W-1:0]  a_q;
  logic [DATA_W-1:0]  b_q;
  logic [ALUOP_W-1:0] aluop_q;

  gpr_file #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N)
  ) u_gpr (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (wb_en),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data),
    .raddr_a_i (in_rs),
    .raddr_b_i (in_rt),
    .rdata_a_o (rd_a),
    .rdata_b_o (rd_b)
  );

  assign imm_ext  = {{(DATA_W-IMM_W){in_imm_sext & in_imm[IMM_W-1]}}, in_imm};
  assign b_d      = in_use_imm ? imm_ext : rd_b;
  // Slot frees up in the same cycle the ALU consumes it, giving back-to-back issue.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Output slot register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      aluop_q <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      a_q     <= rd_a;
      b_q     <= b_d;
      aluop_q <= in_aluop;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_aluop = aluop_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: a reference model predicts issued operands into a queue,
// and a monitor compares every presented output slot against the queue head.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rs = '0;
  logic [4:0]  in_rt = '0;
  logic [15:0] in_imm = '0;
  logic        in_use_imm = 1'b0;
  logic        in_imm_sext = 1'b0;
  logic [2:0]  in_aluop = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [2:0]  out_aluop;

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_W(32), .REG_N(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .in_imm      (in_imm),
    .in_use_imm  (in_use_imm),
    .in_imm_sext (in_imm_sext),
    .in_aluop    (in_aluop),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_aluop   (out_aluop)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } exp_t;

  exp_t        q[$];
  exp_t        e_m;
  logic [31:0] gpr [32];
  bit          model_full;
  bit          acc_m;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Register contents seen by an instruction accepted this cycle.
  function automatic logic [31:0] mread(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
`ifdef ISSUE_BYPASS_EN
    if (wb_en && wb_addr == r) return wb_data;
`endif
    return gpr[r];
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) gpr[i] = '0;
    model_full = 1'b0;
  end

  // Reference model: predicts accepted instructions at each clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) gpr[i] = '0;
      q.delete();
      model_full = 1'b0;
    end else begin
      acc_m = in_valid && (!model_full || out_ready);
      if (acc_m) begin
        e_m.a  = mread(in_rs);
        e_m.b  = in_use_imm ? (in_imm_sext ? 32'($signed(in_imm)) : 32'(in_imm)) : mread(in_rt);
        e_m.op = in_aluop;
        q.push_back(e_m);
      end
      if (acc_m) model_full = 1'b1;
      else if (out_ready) model_full = 1'b0;
      if (wb_en && wb_addr != 5'd0) gpr[wb_addr] = wb_data;
    end
  end

  // Monitor: compares the presented slot with the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, (q.size() == 0) || out_ready});
      if (q.size() > 0) begin
        chk("out_valid", {31'd0, out_valid}, 32'd1);
        chk("out_a", out_a, q[0].a);
        chk("out_b", out_b, q[0].b);
        chk("out_aluop", {29'd0, out_aluop}, {29'd0, q[0].op});
        if (out_ready) void'(q.pop_front());
      end else begin
        chk("out_valid_idle", {31'd0, out_valid}, 32'd0);
      end
    end
  end

  task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [15:0] imm, input logic ui, input logic sx,
                      input logic [2:0] op, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic ordy);
    in_valid = v; in_rs = rs; in_rt = rt; in_imm = imm; in_use_imm = ui;
    in_imm_sext = sx; in_aluop = op; wb_en = we; wb_addr = wa; wb_data = wd;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_out_b", out_b, 32'd0);
    chk("rst_out_aluop", {29'd0, out_aluop}, 32'd0);
  endtask

  initial begin
    #12;
    chk_reset_state();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic issue from registers
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 32'h7, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd4, 32'h4, 1);
    step(1, 5'd7, 5'd4, 0, 0, 0, 3'b000, 0, 0, 0, 1);
    // Immediate extension, sign then zero
    step(1, 5'd7, 5'd4, 16'hFFFC, 1, 1, 3'b001, 0, 0, 0, 1);
    step(1, 5'd7, 5'd4, 16'hFFFC, 1, 0, 3'b010, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Backpressure: hold for three cycles, then back-to-back issue
    step(1, 5'd7, 5'd4, 0, 0, 0, 3'b011, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 5'd4, 5'd7, 0, 0, 0, 3'b100, 0, 0, 0, 0);
    step(1, 5'd4, 5'd7, 0, 0, 0, 3'b100, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Zero register writes are discarded
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd0, 32'hDEADBEEF, 1);
    step(1, 5'd0, 5'd0, 0, 0, 0, 3'b101, 0, 0, 0, 1);

    // Write and read of r5 in the same cycle
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd5, 32'h55, 1);
    step(1, 5'd5, 5'd5, 0, 0, 0, 3'b110, 1, 5'd5, 32'h1234, 1);
    step(1, 5'd5, 5'd5, 0, 0, 0, 3'b111, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, 5'($urandom), 5'($urandom), 16'($urandom),
           1'($urandom), 1'($urandom), 3'($urandom),
           ($urandom % 2) == 0, 5'($urandom % 8), $urandom, ($urandom % 4) != 0);
    end
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 32'hCAFE0007, 1);

    // Reset while the slot is full and stalled
    step(1, 5'd7, 5'd7, 0, 0, 0, 3'b010, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk_reset_state();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1, 5'd7, 5'd7, 0, 0, 0, 3'b001, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("scoreboard_empty", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
